// File: rtl/lfsr_parity_gen_if.sv
// Handshake and status bundle for the LFSR parity generator.
// The master modport belongs to the block that requests words and consumes them.
// The slave modport belongs to the generator itself.
interface lfsr_parity_gen_if #(
  parameter int WIDTH = 7
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             out_valid;
  logic             load_ack;
  logic             seed_err;
  logic             wrap;
  logic [WIDTH-1:0] period_len;

  modport master (
    output en, load, seed_in, out_ready,
    input  out_data, out_valid, load_ack, seed_err, wrap, period_len
  );

  modport slave (
    input  en, load, seed_in, out_ready,
    output out_data, out_valid, load_ack, seed_err, wrap, period_len
  );
endinterface

// File: rtl/lfsr_parity_gen.sv
// Fibonacci LFSR word source with a parity bit and valid/ready output.
// It measures the sequence period by counting transfers until the start seed comes back.
module lfsr_parity_gen #(
  parameter int             WIDTH      = 7,
  parameter logic [WIDTH-1:0] TAPS     = 7'h60,
  parameter logic [WIDTH-1:0] SEED     = 7'h01,
  parameter bit             PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_parity_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH:0]   out_data_q;
  logic             out_valid_q;
  logic             load_ack_q;
  logic             seed_err_q;
  logic             wrap_q;

  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] seed_sel;
  logic             seed_zero;
  logic             xfer;

  // Compute the next state. If the taps would shift in an all-zero state, fall back to SEED.
  // This keeps the register out of the lockup state for any tap mask.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = {s[WIDTH-2:0], ^(s & TAPS)};
    if (n == '0) n = SEED;
    return n;
  endfunction

  // Form the output word as {parity, state}.
  function automatic logic [WIDTH:0] frame(input logic [WIDTH-1:0] s);
    return {(^s) ^ PARITY_ODD, s};
  endfunction

  // Next-state, seed selection and transfer decode.
  always_comb begin
    state_nxt = lfsr_next(state_q);
    seed_zero = (bus.seed_in == '0);
    seed_sel  = seed_zero ? SEED : bus.seed_in;
    xfer      = out_valid_q & bus.out_ready;
  end

  // Control FSM. All outputs are registered here, so they change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= SEED;
      start_q     <= SEED;
      cnt_q       <= '0;
      period_q    <= '0;
      out_data_q  <= frame(SEED);
      out_valid_q <= 1'b0;
      load_ack_q  <= 1'b0;
      seed_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      load_ack_q <= 1'b0;
      wrap_q     <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.load) begin
            // A load takes priority over en. The FSM stays in IDLE for this cycle.
            state_q    <= seed_sel;
            start_q    <= seed_sel;
            cnt_q      <= '0;
            out_data_q <= frame(seed_sel);
            load_ack_q <= 1'b1;
            seed_err_q <= seed_zero;
          end else if (bus.en) begin
            fsm_q       <= RUN;
            out_valid_q <= 1'b1;
          end
        end
        RUN: begin
          // The state moves only when the consumer takes the word. A stalled word is held unchanged.
          if (xfer) begin
            state_q    <= state_nxt;
            out_data_q <= frame(state_nxt);
            if (state_nxt == start_q) begin
              wrap_q   <= 1'b1;
              period_q <= cnt_q + 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
            // Leave RUN only on a transfer, so out_valid is never dropped while a word is pending.
            if (!bus.en) begin
              fsm_q       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.seed_err   = seed_err_q;
  assign bus.wrap       = wrap_q;
  assign bus.period_len = period_q;

endmodule

// File: doc/lfsr_parity_gen.md
LFSR_PARITY_GEN -- requirements
Module: lfsr_parity_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 7: LFSR state width, legal 3..32.
REQ-002 SHALL have parameter TAPS, default 7'h60: feedback mask, bit i set = state[i] feeds the XOR.
REQ-003 SHALL have parameter SEED, default 7'h01: reset/fallback state, nonzero.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity bit, 1 = odd.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  in  1  request generation; sampled every cycle.
REQ-008 SHALL have port load  in  1  seed-load strobe, honoured only in IDLE.
REQ-009 SHALL have port seed_in  in  WIDTH  seed value for load.
REQ-010 SHALL have port out_ready  in  1  consumer accepts out_data.
REQ-011 SHALL have port out_data  out  WIDTH+1  {parity, lfsr_state}.
REQ-012 SHALL have port out_valid  out  1  out_data valid.
REQ-013 SHALL have port load_ack  out  1  one-cycle pulse: load accepted.
REQ-014 SHALL have port seed_err  out  1  sticky: zero seed was rejected.
REQ-015 SHALL have port wrap  out  1  one-cycle pulse: sequence returned to start seed.
REQ-016 SHALL have port period_len  out  WIDTH  transfers counted at last wrap.

Function
REQ-017 SHALL advance Fibonacci style: fb = XOR(state & TAPS); next = {state[WIDTH-2:0], fb}.
REQ-018 SHALL drive out_data[WIDTH] = XOR(state) XOR PARITY_ODD; out_data[WIDTH-1:0] = state; both registered.
REQ-019 SHALL implement FSM IDLE/RUN; out_valid = 1 exactly in RUN.
REQ-020 SHALL move IDLE->RUN on the edge where en=1 and load=0; load=1 in IDLE takes priority, FSM stays IDLE that cycle.
REQ-021 SHALL advance state only on transfer (out_valid & out_ready); out_data held stable while out_valid=1 and out_ready=0.
REQ-022 SHALL go RUN->IDLE only on a transfer cycle with en=0; en=0 without transfer keeps RUN (valid never withdrawn).
REQ-023 SHALL, on load in IDLE with seed_in != 0: state <= seed_in, start_seed <= seed_in, transfer count <= 0, load_ack=1 next cycle, seed_err cleared.
REQ-024 SHALL, on load in IDLE with seed_in == 0: state <= SEED, start_seed <= SEED, count <= 0, load_ack=1, seed_err set.
REQ-025 SHALL ignore load in RUN: no state change, no load_ack.
REQ-026 SHALL keep state nonzero at all times (all-zero lockup unreachable).
REQ-027 SHALL count transfers in a WIDTH-bit counter; on a transfer whose next state equals start_seed: wrap=1 next cycle, period_len <= count+1, counter <= 0.
REQ-028 SHALL hold period_len between wraps; counter wraps modulo 2^WIDTH if taps are non-maximal and seed never recurs.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set: FSM IDLE, state=SEED, start_seed=SEED, count=0, out_valid=0, load_ack=0, seed_err=0, wrap=0, period_len=0; out_data={parity(SEED),SEED}.
REQ-030 SHALL let rst override en/load/out_ready in the same cycle, including mid-RUN with a stalled transfer.

Verification
REQ-031 SHALL check reset: rst 1 cycle -> out_valid=0, out_data=0x81, seed_err=0, period_len=0.
REQ-032 SHALL check free run: en=1, out_ready=1 -> out_data transfers 0x81,0x82,0x84,0x88,0x90,0xA0,0x41,0x03.
REQ-033 SHALL check backpressure: out_ready=0 for 5 cycles at 0x88 -> out_data stays 0x88, out_valid stays 1, next transfer 0x90.
REQ-034 SHALL check period: 127 consecutive transfers from seed 0x01 -> wrap pulses once, period_len=127, out_data back to 0x81.
REQ-035 SHALL check loads: seed_in=0x00 in IDLE -> load_ack, seed_err=1, state 0x01; seed_in=0x41 -> seed_err=0, out_data=0x41; load in RUN -> ignored.
REQ-036 SHALL check reset mid-run: rst during stalled RUN -> next cycle out_valid=0, out_data=0x81, FSM IDLE.
